// File: rtl/dmem_ctrl_if.sv
// Bus bundle for dmem_ctrl: CPU port, loader/debug port and the single-port RAM side.
// The controller connects as slave; the environment (CPU, loader and RAM) drives the master side.
interface dmem_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic [31:0] ld_rdata;
  logic        ld_ready;

  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_err,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_rdata, ld_ready,
    output ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_err,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_rdata, ld_ready,
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: arbitrates a CPU port (RV32 B/H/W loads and stores) and a word-only
// loader port onto one word-wide RAM; sub-word stores are done as read-modify-write.
module dmem_ctrl #(
  parameter bit RR_INIT = 1'b1
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = loader
  logic        last_q, last_d;    // owner of the most recent grant
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        grant_cpu, grant_ld;
  logic        cpu_bad;
  logic        ram_we_c;
  logic [31:0] merged;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] sh;
    logic [15:0] half;
    sh   = w >> {a, 3'b000};
    half = a[1] ? w[31:16] : w[15:0];
    unique case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_ext = {24'h0, sh[7:0]};
      3'b001:  load_ext = {{16{half[15]}}, half};
      3'b101:  load_ext = {16'h0, half};
      default: load_ext = w;
    endcase
  endfunction

  // On a tie the requester that did not win last time is served.
  assign grant_cpu = bus.cpu_req && (!bus.ld_req || last_q);
  assign grant_ld  = bus.ld_req && !grant_cpu;

  always_comb begin
    cpu_bad = 1'b0;
    unique case (bus.cpu_funct3)
      3'b011, 3'b110, 3'b111: cpu_bad = 1'b1;
      3'b001, 3'b101:         cpu_bad = bus.cpu_addr[0];
      3'b010:                 cpu_bad = (bus.cpu_addr[1:0] != 2'b00);
      default:                cpu_bad = 1'b0;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ram_we_c = 1'b0;
    bus.ram_din = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_ld) begin
          owner_d  = 1'b1;
          last_d   = 1'b1;
          we_d     = bus.ld_we;
          funct3_d = 3'b010;
          addr_d   = bus.ld_addr;
          wdata_d  = bus.ld_wdata;
          rdata_d  = 32'h0;
          err_d    = 1'b0;
          state_d  = StAccess;
        end else if (grant_cpu) begin
          owner_d  = 1'b0;
          last_d   = 1'b0;
          we_d     = bus.cpu_we;
          funct3_d = bus.cpu_funct3;
          addr_d   = bus.cpu_addr;
          wdata_d  = bus.cpu_wdata;
          rdata_d  = 32'h0;
          err_d    = cpu_bad;
          state_d  = cpu_bad ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (!we_q) begin
          rdata_d = load_ext(bus.ram_dout, funct3_q, addr_q[1:0]);
          state_d = StResp;
        end else if (funct3_q == 3'b010) begin
          ram_we_c = 1'b1;
          state_d  = StResp;
        end else begin
          merge_d = bus.ram_dout;
          state_d = StWrite;
        end
      end
      StWrite: begin
        ram_we_c    = 1'b1;
        bus.ram_din = merged;
        state_d     = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= RR_INIT;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Reset blocks the write in the same cycle, so an abandoned store never lands.
  assign bus.ram_we    = ram_we_c && !rst;
  assign bus.ram_addr  = {addr_q[31:2], 2'b00};
  assign bus.cpu_ready = (state_q == StResp) && !owner_q;
  assign bus.ld_ready  = (state_q == StResp) && owner_q;
  assign bus.cpu_rdata = bus.cpu_ready ? rdata_q : 32'h0;
  assign bus.cpu_err   = bus.cpu_ready && err_q;
  assign bus.ld_rdata  = bus.ld_ready ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a 256-word behavioural RAM (addr[9:2] decode).
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_ctrl_if bus();

  dmem_ctrl #(.RR_INIT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [256];
  assign bus.ram_dout = mem[bus.ram_addr[9:2]];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr[9:2]] <= bus.ram_din;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one CPU access and waits (bounded) for cpu_ready; wemask bit i = ram_we seen i cycles on.
  task automatic cpu_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output int wemask);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_funct3 = f3;
    bus.cpu_addr = a; bus.cpu_wdata = wd;
    lat = -1; rd = 32'hx; er = 1'bx; wemask = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.ram_we) wemask |= (1 << i);
      if (bus.cpu_ready) begin
        lat = i; rd = bus.cpu_rdata; er = bus.cpu_err;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic ld_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd);
    bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = wd;
    lat = -1; rd = 32'hx;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.ld_ready) begin
        lat = i; rd = bus.ld_rdata;
        break;
      end
    end
    bus.ld_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, wm, ct, lt;
    logic [31:0] rd, lrd;
    logic        er;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_funct3 = 3'b010; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = 0; bus.ld_wdata = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_cpu_ready", {31'h0, bus.cpu_ready}, 32'h0);
    check("rst_ld_ready",  {31'h0, bus.ld_ready},  32'h0);
    check("rst_cpu_err",   {31'h0, bus.cpu_err},   32'h0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_ld_rdata",  bus.ld_rdata,  32'h0);
    check("rst_ram_we",    {31'h0, bus.ram_we},    32'h0);

    // Word store / load
    cpu_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, er, wm);
    check("sw_lat", lat, 2);
    check("sw_we_cycles", wm, 32'h2);
    check("sw_err", {31'h0, er}, 32'h0);
    check("sw_mem", mem[8'h40], 32'hDEADBEEF);
    cpu_op(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, wm);
    check("lw_lat", lat, 2);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_no_we", wm, 32'h0);

    // Byte store (read-modify-write) and byte loads
    cpu_op(1'b1, 3'b010, 32'h100, 32'h11223344, lat, rd, er, wm);
    cpu_op(1'b1, 3'b000, 32'h101, 32'h000000AA, lat, rd, er, wm);
    check("sb_lat", lat, 3);
    check("sb_we_cycles", wm, 32'h4);
    check("sb_mem", mem[8'h40], 32'h1122AA44);
    cpu_op(1'b0, 3'b000, 32'h101, 32'h0, lat, rd, er, wm);
    check("lb_data", rd, 32'hFFFFFFAA);
    cpu_op(1'b0, 3'b100, 32'h101, 32'h0, lat, rd, er, wm);
    check("lbu_data", rd, 32'h000000AA);

    // Half store and half loads
    cpu_op(1'b1, 3'b010, 32'h100, 32'h11223344, lat, rd, er, wm);
    cpu_op(1'b1, 3'b001, 32'h102, 32'h00008001, lat, rd, er, wm);
    check("sh_lat", lat, 3);
    check("sh_mem", mem[8'h40], 32'h80013344);
    cpu_op(1'b0, 3'b001, 32'h102, 32'h0, lat, rd, er, wm);
    check("lh_data", rd, 32'hFFFF8001);
    cpu_op(1'b0, 3'b101, 32'h102, 32'h0, lat, rd, er, wm);
    check("lhu_data", rd, 32'h00008001);
    cpu_op(1'b0, 3'b000, 32'h100, 32'h0, lat, rd, er, wm);
    check("lb_lane0", rd, 32'h00000044);

    // Misaligned and illegal accesses
    cpu_op(1'b0, 3'b010, 32'h103, 32'h0, lat, rd, er, wm);
    check("mis_lat", lat, 1);
    check("mis_err", {31'h0, er}, 32'h1);
    check("mis_rdata", rd, 32'h0);
    check("mis_no_we", wm, 32'h0);
    cpu_op(1'b1, 3'b011, 32'h100, 32'h55555555, lat, rd, er, wm);
    check("ill_lat", lat, 1);
    check("ill_err", {31'h0, er}, 32'h1);
    check("ill_no_we", wm, 32'h0);
    check("ill_mem_kept", mem[8'h40], 32'h80013344);
    cpu_op(1'b1, 3'b001, 32'h101, 32'h0000FFFF, lat, rd, er, wm);
    check("sh_mis_err", {31'h0, er}, 32'h1);

    // 1 KB aliasing
    cpu_op(1'b0, 3'b010, 32'h500, 32'h0, lat, rd, er, wm);
    check("alias_data", rd, 32'h80013344);

    // Loader word write (low address bits ignored) and read
    ld_op(1'b1, 32'h203, 32'hCAFEF00D, lat, rd);
    check("ld_wr_lat", lat, 2);
    check("ld_wr_mem", mem[8'h80], 32'hCAFEF00D);
    ld_op(1'b0, 32'h200, 32'h0, lat, rd);
    check("ld_rd_data", rd, 32'hCAFEF00D);

    // Ties after reset: CPU first, then loader; the next tie goes to the CPU again
    rst = 1'b1; tick(); rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b010; bus.cpu_addr = 32'h200;
      bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h200;
      ct = -1; lt = -1; lrd = 32'hx;
      for (int i = 1; i <= 12; i++) begin
        tick();
        if (bus.cpu_ready && ct < 0) begin ct = i; bus.cpu_req = 1'b0; end
        if (bus.ld_ready && lt < 0) begin lt = i; lrd = bus.ld_rdata; bus.ld_req = 1'b0; end
        if (ct > 0 && lt > 0) break;
      end
      bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
      tick();
      check(r == 0 ? "tie1_cpu_lat" : "tie2_cpu_lat", ct, 2);
      check(r == 0 ? "tie1_ld_after" : "tie2_ld_after", {31'h0, (lt > ct)}, 32'h1);
      check(r == 0 ? "tie1_ld_data" : "tie2_ld_data", lrd, 32'hCAFEF00D);
    end

    // Reset during the WRITE cycle of a byte store
    cpu_op(1'b1, 3'b010, 32'h100, 32'h11223344, lat, rd, er, wm);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_funct3 = 3'b000;
    bus.cpu_addr = 32'h101; bus.cpu_wdata = 32'hAA;
    tick();
    check("rstw_access_no_we", {31'h0, bus.ram_we}, 32'h0);
    tick();
    check("rstw_write_we", {31'h0, bus.ram_we}, 32'h1);
    rst = 1'b1; bus.cpu_req = 1'b0;
    #1;
    check("rstw_we_gated", {31'h0, bus.ram_we}, 32'h0);
    tick();
    rst = 1'b0;
    check("rstw_mem", mem[8'h40], 32'h11223344);
    check("rstw_no_ready", {31'h0, bus.cpu_ready}, 32'h0);
    tick();
    check("rstw_no_ready2", {31'h0, bus.cpu_ready}, 32'h0);
    check("rstw_no_we2", {31'h0, bus.ram_we}, 32'h0);
    cpu_op(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, wm);
    check("rstw_idle_lat", lat, 2);
    check("rstw_idle_data", rd, 32'h11223344);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
